// File: rtl/hpc3_mul_bank.sv
// hpc3_mul_bank: NUM_CHANNELS HPC3 masked AND gadgets that share operand a, followed by optional output register stages.
// Optional macro HPC3_MUL_BANK_TXN_COUNT_EN adds a 16-bit accepted-transaction counter on out_txn_count.
module hpc3_mul_bank #(
    parameter int NUM_SHARES   = 3,
    parameter int BIT_WIDTH    = 1,
    parameter int NUM_CHANNELS = 2,
    parameter int PIPE_STAGES  = 0,
    localparam int NUM_QUADRATIC = NUM_SHARES * (NUM_SHARES - 1) / 2
) (
    input  logic                                          in_clock,
    input  logic                                          in_reset,
    input  logic                                          in_valid,
    input  logic [NUM_SHARES*BIT_WIDTH-1:0]               in_a,
    input  logic [NUM_CHANNELS*NUM_SHARES*BIT_WIDTH-1:0]  in_b,
    input  logic [NUM_CHANNELS*NUM_QUADRATIC*BIT_WIDTH-1:0] in_r,
    input  logic [NUM_CHANNELS*NUM_QUADRATIC*BIT_WIDTH-1:0] in_p,
    output logic [NUM_CHANNELS*NUM_SHARES*BIT_WIDTH-1:0]  out_c,
    output logic                                          out_valid,
    output logic [15:0]                                   out_txn_count
);

    // Handshake: valid-only. in_valid qualifies in_a/in_b/in_r/in_p for one cycle; there is
    // no ready, so the consumer must take out_c on every cycle out_valid is high.

    localparam int NP = NUM_SHARES - 1;
    localparam int CW = NUM_CHANNELS * NUM_SHARES * BIT_WIDTH;

    typedef logic [BIT_WIDTH-1:0] lane_t;

    if (NUM_SHARES < 2) begin : g_chk_shares
        $fatal(1, "hpc3_mul_bank: NUM_SHARES must be >= 2");
    end
    if (NUM_CHANNELS < 1) begin : g_chk_channels
        $fatal(1, "hpc3_mul_bank: NUM_CHANNELS must be >= 1");
    end
    if (PIPE_STAGES < 0 || PIPE_STAGES > 3) begin : g_chk_pipe
        $fatal(1, "hpc3_mul_bank: PIPE_STAGES must be in 0..3");
    end

    // Unordered pair (i,j) -> row-major index over i<j.
    function automatic int pair_idx(input int i, input int j);
        int lo;
        int hi;
        lo = (i < j) ? i : j;
        hi = (i < j) ? j : i;
        return lo * NUM_SHARES - (lo * (lo + 1)) / 2 + (hi - lo - 1);
    endfunction

    // Share i's m-th partner, skipping i itself.
    function automatic int partner(input int i, input int m);
        return (m < i) ? m : m + 1;
    endfunction

    lane_t [NUM_CHANNELS-1:0][NUM_SHARES-1:0]         ab_q, ab_d;
    lane_t [NUM_CHANNELS-1:0][NUM_SHARES-1:0][NP-1:0] u_q, u_d;
    lane_t [NUM_CHANNELS-1:0][NUM_SHARES-1:0][NP-1:0] v_q, v_d;

    always_comb begin
        lane_t a_s;
        lane_t b_s;
        lane_t r_s;
        lane_t p_s;
        int    j;
        int    q;
        a_s  = '0;
        b_s  = '0;
        r_s  = '0;
        p_s  = '0;
        j    = 0;
        q    = 0;
        ab_d = '0;
        u_d  = '0;
        v_d  = '0;
        for (int k = 0; k < NUM_CHANNELS; k++) begin
            for (int i = 0; i < NUM_SHARES; i++) begin
                a_s = in_a[i*BIT_WIDTH +: BIT_WIDTH];
                ab_d[k][i] = a_s & in_b[(k*NUM_SHARES + i)*BIT_WIDTH +: BIT_WIDTH];
                for (int m = 0; m < NP; m++) begin
                    j   = partner(i, m);
                    q   = pair_idx(i, j);
                    b_s = in_b[(k*NUM_SHARES + j)*BIT_WIDTH +: BIT_WIDTH];
                    // Only channel k's own r/p slice is ever touched here.
                    r_s = in_r[(k*NUM_QUADRATIC + q)*BIT_WIDTH +: BIT_WIDTH];
                    p_s = in_p[(k*NUM_QUADRATIC + q)*BIT_WIDTH +: BIT_WIDTH];
                    u_d[k][i][m] = a_s & (b_s ^ r_s);
                    v_d[k][i][m] = (~a_s & r_s) ^ p_s;
                end
            end
        end
    end

    // Gadget registers load only on accepted transactions so shares stay static while idle.
    always_ff @(posedge in_clock or negedge in_reset) begin
        if (!in_reset) begin
            ab_q <= '0;
            u_q  <= '0;
            v_q  <= '0;
        end else if (in_valid) begin
            ab_q <= ab_d;
            u_q  <= u_d;
            v_q  <= v_d;
        end
    end

    logic [CW-1:0] gadget_c;

    always_comb begin
        lane_t acc;
        acc      = '0;
        gadget_c = '0;
        for (int k = 0; k < NUM_CHANNELS; k++) begin
            for (int i = 0; i < NUM_SHARES; i++) begin
                acc = ab_q[k][i];
                for (int m = 0; m < NP; m++) begin
                    acc = acc ^ u_q[k][i][m] ^ v_q[k][i][m];
                end
                gadget_c[(k*NUM_SHARES + i)*BIT_WIDTH +: BIT_WIDTH] = acc;
            end
        end
    end

    // vld_q[s] travels alongside stage_c[s]; vld_q[0] marks fresh gadget contents.
    logic [PIPE_STAGES:0]         vld_q, vld_d;
    logic [PIPE_STAGES:0][CW-1:0] stage_c;

    always_comb begin
        vld_d    = '0;
        vld_d[0] = in_valid;
        for (int s = 1; s <= PIPE_STAGES; s++) begin
            vld_d[s] = vld_q[s-1];
        end
    end

    always_ff @(posedge in_clock or negedge in_reset) begin
        if (!in_reset) begin
            vld_q <= '0;
        end else begin
            vld_q <= vld_d;
        end
    end

    assign stage_c[0] = gadget_c;

    for (genvar s = 0; s < PIPE_STAGES; s++) begin : g_pipe
        logic [CW-1:0] data_q;
        always_ff @(posedge in_clock or negedge in_reset) begin
            if (!in_reset) begin
                data_q <= '0;
            end else if (vld_q[s]) begin
                data_q <= stage_c[s];
            end
        end
        assign stage_c[s+1] = data_q;
    end

    assign out_c     = stage_c[PIPE_STAGES];
    assign out_valid = vld_q[PIPE_STAGES];

`ifdef HPC3_MUL_BANK_TXN_COUNT_EN
    logic [15:0] txn_cnt_q, txn_cnt_d;

    assign txn_cnt_d = txn_cnt_q + 16'd1;

    always_ff @(posedge in_clock or negedge in_reset) begin
        if (!in_reset) begin
            txn_cnt_q <= '0;
        end else if (in_valid) begin
            txn_cnt_q <= txn_cnt_d;
        end
    end

    assign out_txn_count = txn_cnt_q;
`else
    assign out_txn_count = 16'd0;
`endif

endmodule

// File: tb/tb_hpc3_mul_bank.sv
// Bench for hpc3_mul_bank: a small instance (3 shares, 1 bit, 2 channels, no pipe) and a wide one
// (3 shares, 4 bits, 4 channels, 3 pipe stages), checked against a share-level model and plain a&b.
module tb_hpc3_mul_bank;

    localparam int S   = 3;
    localparam int Q   = 3;
    localparam int BW0 = 1;
    localparam int CH0 = 2;
    localparam int P0  = 0;
    localparam int BW1 = 4;
    localparam int CH1 = 4;
    localparam int P1  = 3;

    // ---------------- clock / reset ----------------
    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    int   edge_cnt = 0;

    always #5 clk = ~clk;
    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    // ---------------- DUT signals ----------------
    logic                  v0, ov0;
    logic [S*BW0-1:0]      a0;
    logic [CH0*S*BW0-1:0]  b0, c0;
    logic [CH0*Q*BW0-1:0]  r0, p0;
    logic [15:0]           cnt0;

    logic                  v1, ov1;
    logic [S*BW1-1:0]      a1;
    logic [CH1*S*BW1-1:0]  b1, c1;
    logic [CH1*Q*BW1-1:0]  r1, p1;
    logic [15:0]           cnt1;

    hpc3_mul_bank #(.NUM_SHARES(S), .BIT_WIDTH(BW0), .NUM_CHANNELS(CH0), .PIPE_STAGES(P0)) u_small (
        .in_clock(clk), .in_reset(rst_n), .in_valid(v0), .in_a(a0), .in_b(b0), .in_r(r0), .in_p(p0),
        .out_c(c0), .out_valid(ov0), .out_txn_count(cnt0)
    );

    hpc3_mul_bank #(.NUM_SHARES(S), .BIT_WIDTH(BW1), .NUM_CHANNELS(CH1), .PIPE_STAGES(P1)) u_wide (
        .in_clock(clk), .in_reset(rst_n), .in_valid(v1), .in_a(a1), .in_b(b1), .in_r(r1), .in_p(p1),
        .out_c(c1), .out_valid(ov1), .out_txn_count(cnt1)
    );

    // ---------------- bookkeeping ----------------
    int n_tests = 0;
    int n_fail  = 0;
    int exp_cnt0 = 0;
    int exp_cnt1 = 0;
    int pidx[S][S];

    typedef struct {
        logic [63:0] c;
        logic [63:0] plain;
        int          due;
    } exp_t;

    exp_t exp_q0[$];
    exp_t exp_q1[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic logic [63:0] share_val(input int bw, input logic [63:0] x);
        logic [63:0] mask;
        logic [63:0] acc;
        logic [63:0] rnd;
        logic [63:0] res;
        mask = (64'd1 << bw) - 64'd1;
        acc  = x & mask;
        res  = '0;
        for (int i = 0; i < S - 1; i++) begin
            rnd = {32'd0, $urandom} & mask;
            res = res | (rnd << (i * bw));
            acc = acc ^ rnd;
        end
        res = res | (acc << ((S - 1) * bw));
        return res;
    endfunction

    // Share i of channel k, per lane: a_i b_i ^ XOR_{j!=i} [a_i(b_j^r_ij) ^ (~a_i r_ij) ^ p_ij].
    function automatic logic [63:0] model_c(input int bw, input int ch, input logic [63:0] a,
                                            input logic [63:0] b, input logic [63:0] r, input logic [63:0] p);
        logic [63:0] c;
        logic ai, bj, rr, pp, acc;
        c = '0;
        for (int k = 0; k < ch; k++) begin
            for (int i = 0; i < S; i++) begin
                for (int l = 0; l < bw; l++) begin
                    ai  = a[i*bw + l];
                    acc = ai & b[(k*S + i)*bw + l];
                    for (int j = 0; j < S; j++) begin
                        if (j != i) begin
                            bj  = b[(k*S + j)*bw + l];
                            rr  = r[(k*Q + pidx[i][j])*bw + l];
                            pp  = p[(k*Q + pidx[i][j])*bw + l];
                            acc = acc ^ (ai & (bj ^ rr)) ^ (~ai & rr) ^ pp;
                        end
                    end
                    c[(k*S + i)*bw + l] = acc;
                end
            end
        end
        return c;
    endfunction

    function automatic logic [63:0] unmask(input int bw, input int ch, input logic [63:0] c);
        logic [63:0] res;
        res = '0;
        for (int k = 0; k < ch; k++) begin
            for (int l = 0; l < bw; l++) begin
                for (int i = 0; i < S; i++) begin
                    res[k*bw + l] = res[k*bw + l] ^ c[(k*S + i)*bw + l];
                end
            end
        end
        return res;
    endfunction

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #2;
        v0 = 1'b0; a0 = S*BW0'($urandom); b0 = CH0*S*BW0'($urandom);
        r0 = CH0*Q*BW0'($urandom); p0 = CH0*Q*BW0'($urandom);
        v1 = 1'b0; a1 = S*BW1'($urandom); b1 = {$urandom, $urandom};
        r1 = {$urandom, $urandom}; p1 = {$urandom, $urandom};
    endtask

    task automatic drive0_raw(input logic [63:0] a_sh, input logic [63:0] b_sh, input logic [63:0] r,
                              input logic [63:0] p, input logic [63:0] pl);
        v0 = 1'b1; a0 = a_sh[S*BW0-1:0]; b0 = b_sh[CH0*S*BW0-1:0];
        r0 = r[CH0*Q*BW0-1:0]; p0 = p[CH0*Q*BW0-1:0];
        exp_q0.push_back('{c: model_c(BW0, CH0, a_sh, b_sh, r, p), plain: pl, due: edge_cnt + 1 + P0});
        exp_cnt0++;
    endtask

    task automatic drive1_raw(input logic [63:0] a_sh, input logic [63:0] b_sh, input logic [63:0] r,
                              input logic [63:0] p, input logic [63:0] pl);
        v1 = 1'b1; a1 = a_sh[S*BW1-1:0]; b1 = b_sh[CH1*S*BW1-1:0];
        r1 = r[CH1*Q*BW1-1:0]; p1 = p[CH1*Q*BW1-1:0];
        exp_q1.push_back('{c: model_c(BW1, CH1, a_sh, b_sh, r, p), plain: pl, due: edge_cnt + 1 + P1});
        exp_cnt1++;
    endtask

    // a_pl is one lane group; b_pl holds channel k's plain value at bits [k*bw +: bw].
    task automatic drive0(input logic [63:0] a_pl, input logic [63:0] b_pl);
        logic [63:0] b_sh, pl, bk, t;
        b_sh = '0; pl = '0;
        for (int k = 0; k < CH0; k++) begin
            bk   = (b_pl >> (k*BW0)) & 64'h1;
            t    = share_val(BW0, bk);
            b_sh = b_sh | (t << (k*S*BW0));
            pl   = pl | ((a_pl & bk & 64'h1) << (k*BW0));
        end
        drive0_raw(share_val(BW0, a_pl), b_sh, {32'd0, $urandom}, {32'd0, $urandom}, pl);
    endtask

    task automatic drive1(input logic [63:0] a_pl, input logic [63:0] b_pl);
        logic [63:0] b_sh, pl, bk, t;
        b_sh = '0; pl = '0;
        for (int k = 0; k < CH1; k++) begin
            bk   = (b_pl >> (k*BW1)) & 64'hF;
            t    = share_val(BW1, bk);
            b_sh = b_sh | (t << (k*S*BW1));
            pl   = pl | ((a_pl & bk & 64'hF) << (k*BW1));
        end
        drive1_raw(share_val(BW1, a_pl), b_sh, {$urandom, $urandom}, {$urandom, $urandom}, pl);
    endtask

    task automatic check_cnt();
`ifdef HPC3_MUL_BANK_TXN_COUNT_EN
        check("u_small txn_count", 64'(cnt0), 64'(exp_cnt0 & 32'hFFFF));
        check("u_wide txn_count", 64'(cnt1), 64'(exp_cnt1 & 32'hFFFF));
`else
        check("u_small txn_count", 64'(cnt0), 64'd0);
        check("u_wide txn_count", 64'(cnt1), 64'd0);
`endif
    endtask

    // ---------------- scoreboard monitor ----------------
    always @(negedge clk) begin : mon
        exp_t e;
        logic ev;
        ev = (exp_q0.size() > 0) && (exp_q0[0].due == edge_cnt);
        check("u_small out_valid", 64'(ov0), 64'(ev));
        if (ev) begin
            e = exp_q0.pop_front();
            if (ov0) begin
                check("u_small out_c shares", 64'(c0), e.c);
                check("u_small unmasked", unmask(BW0, CH0, 64'(c0)), e.plain);
            end
        end
        ev = (exp_q1.size() > 0) && (exp_q1[0].due == edge_cnt);
        check("u_wide out_valid", 64'(ov1), 64'(ev));
        if (ev) begin
            e = exp_q1.pop_front();
            if (ov1) begin
                check("u_wide out_c shares", 64'(c1), e.c);
                check("u_wide unmasked", unmask(BW1, CH1, 64'(c1)), e.plain);
            end
        end
    end

    // ---------------- test sequence ----------------
    typedef struct {
        logic a;
        logic b0;
        logic b1;
        logic c0;
        logic c1;
    } vec_t;

    vec_t        tbl[8];
    logic [63:0] held0, held1, base;
    logic [63:0] a_sh, b_sh, one_b, r_ch, pl;
    logic [7:0]  nn;

    initial begin
        int q;
        q = 0;
        for (int i = 0; i < S; i++) begin
            for (int j = i + 1; j < S; j++) begin
                pidx[i][j] = q;
                pidx[j][i] = q;
                q++;
            end
            pidx[i][i] = 0;
        end

        tbl[0] = '{a: 1'b0, b0: 1'b0, b1: 1'b0, c0: 1'b0, c1: 1'b0};
        tbl[1] = '{a: 1'b0, b0: 1'b1, b1: 1'b0, c0: 1'b0, c1: 1'b0};
        tbl[2] = '{a: 1'b0, b0: 1'b0, b1: 1'b1, c0: 1'b0, c1: 1'b0};
        tbl[3] = '{a: 1'b0, b0: 1'b1, b1: 1'b1, c0: 1'b0, c1: 1'b0};
        tbl[4] = '{a: 1'b1, b0: 1'b0, b1: 1'b0, c0: 1'b0, c1: 1'b0};
        tbl[5] = '{a: 1'b1, b0: 1'b1, b1: 1'b0, c0: 1'b1, c1: 1'b0};
        tbl[6] = '{a: 1'b1, b0: 1'b0, b1: 1'b1, c0: 1'b0, c1: 1'b1};
        tbl[7] = '{a: 1'b1, b0: 1'b1, b1: 1'b1, c0: 1'b1, c1: 1'b1};

        v0 = 1'b0; a0 = '0; b0 = '0; r0 = '0; p0 = '0;
        v1 = 1'b0; a1 = '0; b1 = '0; r1 = '0; p1 = '0;

        // Reset state
        #1 rst_n = 1'b0;
        #1;
        check("reset u_small out_c", 64'(c0), 64'd0);
        check("reset u_small out_valid", 64'(ov0), 64'd0);
        check("reset u_wide out_c", 64'(c1), 64'd0);
        check("reset u_wide out_valid", 64'(ov1), 64'd0);
        check_cnt();
        tick(); tick();
        rst_n = 1'b1;
        tick();

        // Table: one transaction, result next cycle, then held with out_valid low
        for (int t = 0; t < 8; t++) begin
            drive0(64'(tbl[t].a), {62'd0, tbl[t].b1, tbl[t].b0});
            tick();
            check("table out_valid", 64'(ov0), 64'd1);
            check("table unmasked", unmask(BW0, CH0, 64'(c0)), {62'd0, tbl[t].c1, tbl[t].c0});
            held0 = 64'(c0);
            tick();
            check("table valid drop", 64'(ov0), 64'd0);
            check("table hold", 64'(c0), held0);
        end
        check_cnt();

        // Idle hold on both instances while inputs toggle
        drive0(64'($urandom_range(0, 1)), 64'($urandom_range(0, 3)));
        drive1(64'($urandom_range(0, 15)), {48'd0, 16'($urandom)});
        tick();
        held0 = 64'(c0);
        tick(); tick(); tick();
        check("idle u_wide latency valid", 64'(ov1), 64'd1);
        held1 = 64'(c1);
        for (int n = 0; n < 10; n++) begin
            tick();
            check("idle u_small hold", 64'(c0), held0);
            check("idle u_wide hold", 64'(c1), held1);
            check("idle u_wide valid low", 64'(ov1), 64'd0);
        end

        // Random traffic with gaps
        for (int n = 0; n < 300; n++) begin
            tick();
            if ($urandom_range(0, 9) < 7) drive0(64'($urandom_range(0, 1)), 64'($urandom_range(0, 3)));
            if ($urandom_range(0, 9) < 7) drive1(64'($urandom_range(0, 15)), {48'd0, 16'($urandom)});
        end
        for (int n = 0; n < 6; n++) tick();
        check_cnt();

        // Exhaustive (a, b0) on the wide instance, back-to-back, random b1..b3
        for (int n = 0; n < 256; n++) begin
            tick();
            nn = n[7:0];
            drive1({60'd0, nn[3:0]}, {48'd0, 12'($urandom), nn[7:4]});
        end
        for (int n = 0; n < 6; n++) tick();
        check("exhaustive drained", 64'(exp_q1.size()), 64'd0);
        check_cnt();

        // Channel independence: identical a/b sharings, per-channel r on pair (0,1)
        a_sh  = share_val(BW1, 64'h9);
        one_b = share_val(BW1, 64'hB);
        b_sh  = '0; r_ch = '0; pl = '0;
        for (int k = 0; k < CH1; k++) begin
            b_sh = b_sh | (one_b << (k*S*BW1));
            r_ch = r_ch | (64'(k) << ((k*Q)*BW1));
            pl   = pl | (64'h9 & 64'hB) << (k*BW1);
        end
        drive1_raw(a_sh, b_sh, r_ch, 64'd0, pl);
        tick(); tick(); tick(); tick();
        check("indep valid", 64'(ov1), 64'd1);
        base = 64'(c1[S*BW1-1:0]);
        for (int k = 1; k < CH1; k++) begin
            check("indep sharings differ", 64'(64'(c1[k*S*BW1 +: S*BW1]) != base), 64'd1);
            check("indep unmasked equal", unmask(BW1, CH1, 64'(c1)) >> (k*BW1) & 64'hF, 64'h9);
        end
        tick();

        // Reset mid-flight on the pipelined instance
        drive1(64'h5, 64'h3333);
        tick();
        drive1(64'hF, 64'hFFFF);
        tick();
        #1;
        exp_q0.delete();
        exp_q1.delete();
        exp_cnt0 = 0;
        exp_cnt1 = 0;
        rst_n = 1'b0;
        #1;
        check("midreset u_wide out_c", 64'(c1), 64'd0);
        check("midreset u_wide out_valid", 64'(ov1), 64'd0);
        check("midreset u_small out_c", 64'(c0), 64'd0);
        check_cnt();
        tick();
        rst_n = 1'b1;
        for (int n = 0; n < 8; n++) begin
            tick();
            check("post-reset no stale valid", 64'(ov1), 64'd0);
        end
        drive1(64'hA, 64'h6C3F);
        for (int n = 0; n < 6; n++) tick();
        check_cnt();

`ifdef HPC3_MUL_BANK_TXN_COUNT_EN
        // Counter wrap on the small instance
        #1;
        exp_q0.delete();
        exp_cnt0 = 0;
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        for (int n = 0; n < 65537; n++) begin
            tick();
            drive0(64'($urandom_range(0, 1)), 64'($urandom_range(0, 3)));
        end
        tick();
        check("u_small txn wrap", 64'(cnt0), 64'd1);
        check_cnt();
        tick();
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
